// File: rtl/pc_gen_if.sv
// Fetch PC generator control/status bundle.
// Master drives the pipeline controls; slave is the PC generator.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            trap_valid_i;
  logic [XLEN-1:0] trap_pc_i;
  logic            halt_i;
  logic            resume_i;
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic [XLEN-1:0] this_pc_o;
  logic [XLEN-1:0] pcplus_o;
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;
  logic [31:0]     fetch_cnt_o;
  logic [1:0]      state_o;

  modport master (
    output stall_i, redirect_valid_i, redirect_pc_i,
    output trap_valid_i, trap_pc_i, halt_i, resume_i,
    input  pc_o, pc_valid_o, this_pc_o, pcplus_o,
    input  misalign_o, misalign_addr_o, fetch_cnt_o, state_o
  );

  modport slave (
    input  stall_i, redirect_valid_i, redirect_pc_i,
    input  trap_valid_i, trap_pc_i, halt_i, resume_i,
    output pc_o, pc_valid_o, this_pc_o, pcplus_o,
    output misalign_o, misalign_addr_o, fetch_cnt_o, state_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: trap/halt/redirect/stall priority,
// one-entry pending redirect buffer, run/halt FSM and fetch counter.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4
) (
  input  logic  clk,
  input  logic  rst,
  pc_gen_if.slave bus
);
  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] MASK = XLEN'(INC - 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INC);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_this_pc;
  logic            r_pend_v;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_mis;
  logic [XLEN-1:0] r_mis_addr;
  logic [31:0]     r_cnt;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_pend_v_nxt;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic            w_mis_nxt;
  logic [XLEN-1:0] w_mis_addr_nxt;
  logic            w_adv;
  logic            w_redir_bad;
  logic [XLEN-1:0] w_trap_pc;

  assign w_redir_bad = |(bus.redirect_pc_i & MASK);
  assign w_trap_pc   = bus.trap_pc_i & ~MASK;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_v_nxt   = r_pend_v;
    w_pend_pc_nxt  = r_pend_pc;
    w_mis_nxt      = 1'b0;
    w_mis_addr_nxt = r_mis_addr;
    w_adv          = 1'b0;
    unique case (r_state)
      S_RESET: w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.trap_valid_i) begin
          w_pc_nxt     = w_trap_pc;
          w_pend_v_nxt = 1'b0;
          w_adv        = 1'b1;
        end else if (bus.halt_i) begin
          w_state_nxt = S_HALT;
          if (bus.redirect_valid_i && w_redir_bad) begin
            w_mis_nxt      = 1'b1;
            w_mis_addr_nxt = bus.redirect_pc_i;
          end else if (bus.redirect_valid_i) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = bus.redirect_pc_i;
          end
        end else if (bus.redirect_valid_i && w_redir_bad) begin
          w_mis_nxt      = 1'b1;
          w_mis_addr_nxt = bus.redirect_pc_i;
        end else if (bus.redirect_valid_i && !bus.stall_i) begin
          w_pc_nxt     = bus.redirect_pc_i;
          w_pend_v_nxt = 1'b0;
          w_adv        = 1'b1;
        end else if (bus.redirect_valid_i) begin
          w_pend_v_nxt  = 1'b1;
          w_pend_pc_nxt = bus.redirect_pc_i;
        end else if (r_pend_v && !bus.stall_i) begin
          w_pc_nxt     = r_pend_pc;
          w_pend_v_nxt = 1'b0;
          w_adv        = 1'b1;
        end else if (!bus.stall_i) begin
          w_pc_nxt = r_pc + STEP;
          w_adv    = 1'b1;
        end
      end
      S_HALT: begin
        if (bus.trap_valid_i) begin
          w_state_nxt  = S_RUN;
          w_pc_nxt     = w_trap_pc;
          w_pend_v_nxt = 1'b0;
          w_adv        = 1'b1;
        end else begin
          if (bus.resume_i) w_state_nxt = S_RUN;
          if (bus.redirect_valid_i && w_redir_bad) begin
            w_mis_nxt      = 1'b1;
            w_mis_addr_nxt = bus.redirect_pc_i;
          end else if (bus.redirect_valid_i) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = bus.redirect_pc_i;
          end
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_VECTOR;
      r_this_pc  <= RESET_VECTOR;
      r_pend_v   <= 1'b0;
      r_pend_pc  <= '0;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_this_pc  <= r_pc;
      r_pend_v   <= w_pend_v_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_mis      <= w_mis_nxt;
      r_mis_addr <= w_mis_addr_nxt;
      r_cnt      <= r_cnt + {31'd0, w_adv};
    end
  end

  assign bus.pc_o            = r_pc;
  assign bus.pc_valid_o      = (r_state == S_RUN);
  assign bus.this_pc_o       = r_this_pc;
  assign bus.pcplus_o        = r_pc + STEP;
  assign bus.misalign_o      = r_mis;
  assign bus.misalign_addr_o = r_mis_addr;
  assign bus.fetch_cnt_o     = r_cnt;
  assign bus.state_o         = r_state;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator for the pipelined RISC-V core, replacing the fixed 32-bit PC register in the IF stage. Each cycle it selects the next fetch address from these sources, in priority order: trap vector, halt hold, branch/jump redirect, stall hold, sequential increment. It keeps a one-entry pending-redirect buffer, so a redirect that arrives during a stall or halt is not lost. It also provides a run/halt state machine, misaligned-target detection, the previous-cycle PC for the IF/ID register, and a fetch counter.

## Interface
Parameters:
- XLEN, 32, address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits).
- INC, 4, sequential increment in bytes. Must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  hazard stall; hold the PC.
- redirect_valid_i  in  1  branch/jump taken, resolved in EX.
- redirect_pc_i  in  XLEN  redirect target.
- trap_valid_i  in  1  trap/exception entry.
- trap_pc_i  in  XLEN  trap vector.
- halt_i  in  1  halt request.
- resume_i  in  1  leave HALT.
- pc_o  out  XLEN  current fetch PC (registered).
- pc_valid_o  out  1  fetch is valid this cycle.
- this_pc_o  out  XLEN  pc_o delayed by one cycle (registered).
- pcplus_o  out  XLEN  pc_o + INC, combinational, mod 2^XLEN.
- misalign_o  out  1  one-cycle pulse: a redirect was rejected.
- misalign_addr_o  out  XLEN  rejected target; held until the next rejection.
- fetch_cnt_o  out  32  count of PC advances.
- state_o  out  2  00 RESET, 01 RUN, 10 HALT.

## Operation
- Reset (rst=1 at an edge, overrides every other input):
  - state=RESET; pc_o=RESET_VECTOR; this_pc_o=RESET_VECTOR.
  - pc_valid_o=0; misalign_o=0; misalign_addr_o=0; fetch_cnt_o=0.
  - Pending buffer cleared.
- RESET state: lasts exactly one cycle after rst deasserts, then moves to RUN. Inputs are ignored in RESET.
- pc_valid_o = (state==RUN).
- RUN next-PC selection, first match wins:
  1. trap_valid_i: PC <= trap_pc_i with the low log2(INC) bits forced to 0. Pending buffer cleared.
  2. halt_i: state <= HALT; PC held. A simultaneous redirect is captured into the pending buffer.
  3. redirect_valid_i with a misaligned target (any of the low log2(INC) bits nonzero):
     - Rejected; PC held.
     - misalign_o=1 for one cycle; misalign_addr_o <= target.
     - Pending buffer unchanged.
  4. redirect_valid_i, aligned, stall_i=0: PC <= redirect_pc_i. Pending buffer cleared.
  5. redirect_valid_i, aligned, stall_i=1: PC held. Target written to the pending buffer, overwriting any older entry.
  6. Pending buffer valid, stall_i=0: PC <= pending target. Pending buffer cleared.
  7. stall_i=1: PC held.
  8. Otherwise: PC <= pc_o + INC, wrapping (e.g. 32'hFFFF_FFFC -> 0).
- HALT state:
  - PC held.
  - trap_valid_i: state <= RUN and the PC loads the trap vector (as in RUN rule 1); pending buffer cleared.
  - resume_i without trap: state <= RUN; PC unchanged.
  - Aligned redirects are captured into the pending buffer; misaligned ones pulse misalign_o.
- this_pc_o <= pc_o on every non-reset edge, including stall and HALT cycles.
- fetch_cnt_o increments by 1 on every RUN edge where the PC is loaded by rule 1, 4, 6 or 8, or on a HALT trap exit. It wraps at 2^32.

## Timing
- Latency: a next-PC decision is visible on pc_o one edge later.
  - A redirect asserted in cycle n appears on pc_o in cycle n+1.
  - A stalled redirect appears one cycle after the first cycle with stall_i=0.
- pcplus_o has zero latency from pc_o.
- misalign_o is registered: asserted in the cycle after the offending input.
- First valid fetch: rst deasserted before edge k -> pc_valid_o=1 from cycle k+1, with pc_o=RESET_VECTOR.

## Test plan
- Reset then free-run with RESET_VECTOR=0, INC=4:
  - pc_o sequence 0,0,4,8,C.
  - pc_valid_o first high with pc_o=0.
  - fetch_cnt_o=3 when pc_o=C.
- Redirect to 0x100 while stall_i=1 for 3 cycles:
  - pc_o holds for those 3 cycles.
  - After the stall drops, pc_o=0x100 on the next cycle.
  - A second redirect to 0x200 during the stall overwrites, giving 0x200.
- Trap to 0x80 together with redirect and stall in the same cycle: pc_o=0x80 next cycle; pending buffer empty afterwards.
- Redirect to 0x102: PC keeps its value; misalign_o pulses once; misalign_addr_o=0x102.
- halt_i together with redirect 0x40:
  - state_o=10 and pc_valid_o=0.
  - resume_i -> state_o=01, then pc_o=0x40.
- Wrap-around and mid-run reset:
  - pc_o=0xFFFF_FFFC advances to 0.
  - rst during a pending redirect -> pc_o=RESET_VECTOR, fetch_cnt_o=0, pending buffer discarded.
